// File: rtl/eth_mac_pkg.sv
// Shared types and constants for the Ethernet MAC TX path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        FCS
    } fcs_state_t;

    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Bit-reversed 0x04C11DB7; the Ethernet CRC shifts LSB first.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam int          ETH_MIN_FRAME = 60;
    localparam int          FCS_BYTES     = 4;

endpackage

// File: rtl/crc32.sv
// Ethernet CRC-32 next-state for one DATA_WIDTH-bit word; the caller owns the state register.
// Latency: combinational, zero cycles.
// Backpressure: none; crc_en low passes i_crc_state through, which freezes the caller's CRC.
//
// Ports:
//   i_byte       data word, bit 0 enters the CRC first
//   i_crc_state  current (un-inverted) CRC state
//   crc_en       update strobe
//   o_crc_state  next CRC state (equals i_crc_state when crc_en is low)
//   crc_out      FCS value for o_crc_state (final inversion applied)
module crc32
    import eth_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic [31:0]           i_crc_state,
    input  logic                  crc_en,
    output logic [31:0]           o_crc_state,
    output logic [31:0]           crc_out
);

    logic [31:0] crc_step;

    always_comb begin
        crc_step = i_crc_state;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (crc_step[0] ^ i_byte[i]) begin
                crc_step = (crc_step >> 1) ^ CRC_POLY_REFL;
            end else begin
                crc_step = crc_step >> 1;
            end
        end
        o_crc_state = crc_en ? crc_step : i_crc_state;
    end

    assign crc_out = ~o_crc_state;

endmodule

// File: rtl/eth_fcs_inserter.sv
// TX frame forwarder that optionally zero-pads short frames and appends the 4-byte FCS, LSB first.
// Latency: one cycle from an accepted input byte to m_axis_tvalid; 1 byte/clk with m_axis_tready high.
// Backpressure: single output register; m_axis_tready low stalls input, padding, FCS and the CRC.
//
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   s_axis_t*             byte-wide input frame (DA..payload, no preamble, no FCS)
//   m_axis_t*             byte-wide output frame (data, optional pad, FCS); tlast on final FCS byte
//   busy                  high from first accepted byte until the last FCS byte is transferred
// Build option: define ETH_FCS_PAD_EN to pad frames shorter than MIN_FRAME_LEN with zeros.
module eth_fcs_inserter
    import eth_mac_pkg::*;
#(
    parameter int MIN_FRAME_LEN = ETH_MIN_FRAME,
    parameter int CNT_WIDTH     = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready,
    output logic       busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [1:0]           FCS_LAST_IDX = 2'(FCS_BYTES - 1);

`ifdef ETH_FCS_PAD_EN
    localparam logic [CNT_WIDTH-1:0] MIN_LEN_C = CNT_WIDTH'(MIN_FRAME_LEN);
`else
    logic unused_min_len;
    assign unused_min_len = ^MIN_FRAME_LEN;
`endif

    fcs_state_t           state;
    logic [31:0]          crc_q;
    logic [31:0]          fcs_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           fcs_idx;
    // Keeps the input closed for the first cycle after reset.
    logic                 in_en;

    logic                 slot_free;
    logic                 in_acc;
    logic                 crc_ld;
    logic [7:0]           crc_byte;
    logic [31:0]          crc_seed;
    logic [31:0]          crc_next;
    logic [31:0]          crc_final;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = in_en && slot_free && (state == IDLE || state == DATA);
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign busy          = (state != IDLE) || m_axis_tvalid;

    // The first byte of every frame is folded into a fresh CRC, so a stale
    // crc_q left over from the previous frame is never used.
    assign crc_seed = (state == IDLE) ? CRC_INIT : crc_q;

    always_comb begin
        crc_ld   = in_acc;
        crc_byte = s_axis_tdata;
`ifdef ETH_FCS_PAD_EN
        if (state == PAD && slot_free) begin
            crc_ld   = 1'b1;
            crc_byte = 8'h00;
        end
`endif
    end

    crc32 #(
        .DATA_WIDTH (8)
    ) u_crc32 (
        .i_byte      (crc_byte),
        .i_crc_state (crc_seed),
        .crc_en      (crc_ld),
        .o_crc_state (crc_next),
        .crc_out     (crc_final)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            crc_q         <= CRC_INIT;
            fcs_q         <= '0;
            cnt           <= '0;
            fcs_idx       <= '0;
            in_en         <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            in_en <= 1'b1;
            if (slot_free) begin
                // Slot drains unless a byte is loaded below.
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                case (state)
                    IDLE: begin
                        if (in_acc) begin
                            m_axis_tdata  <= s_axis_tdata;
                            m_axis_tvalid <= 1'b1;
                            crc_q         <= crc_next;
                            cnt           <= CNT_ONE;
                            fcs_idx       <= '0;
                            state         <= DATA;
                            if (s_axis_tlast) begin
                                state <= FCS;
                                fcs_q <= crc_final;
`ifdef ETH_FCS_PAD_EN
                                if (CNT_ONE < MIN_LEN_C) begin
                                    state <= PAD;
                                end
`endif
                            end
                        end
                    end
                    DATA: begin
                        if (in_acc) begin
                            m_axis_tdata  <= s_axis_tdata;
                            m_axis_tvalid <= 1'b1;
                            crc_q         <= crc_next;
                            cnt           <= cnt_inc;
                            if (s_axis_tlast) begin
                                state <= FCS;
                                fcs_q <= crc_final;
`ifdef ETH_FCS_PAD_EN
                                if (cnt_inc < MIN_LEN_C) begin
                                    state <= PAD;
                                end
`endif
                            end
                        end
                    end
`ifdef ETH_FCS_PAD_EN
                    PAD: begin
                        m_axis_tdata  <= 8'h00;
                        m_axis_tvalid <= 1'b1;
                        crc_q         <= crc_next;
                        cnt           <= cnt_inc;
                        if (cnt_inc >= MIN_LEN_C) begin
                            state <= FCS;
                            fcs_q <= crc_final;
                        end
                    end
`endif
                    FCS: begin
                        m_axis_tdata  <= fcs_q[{fcs_idx, 3'b000} +: 8];
                        m_axis_tvalid <= 1'b1;
                        if (fcs_idx == FCS_LAST_IDX) begin
                            m_axis_tlast <= 1'b1;
                            fcs_idx      <= '0;
                            state        <= IDLE;
                        end else begin
                            fcs_idx <= fcs_idx + 2'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/eth_fcs_inserter.md
Name: eth_fcs_inserter

Overview:
- TX-path controller that sequences the crc32 datapath (DATA_WIDTH=8) over an outgoing Ethernet frame and appends the 4-byte FCS.
- Accepts a byte-wide AXI-Stream frame (destination MAC through payload, no preamble or FCS) and forwards it unchanged.
- Optionally zero-pads short frames to the minimum length, then emits the FCS least-significant byte first.
- Sits between the TX FIFO and the MAC TX preamble/serialiser.

Parameters:
- MIN_FRAME_LEN, 60, minimum bytes before the FCS (pad target); used only when padding is compiled in.
- CNT_WIDTH, 11, width of the byte counter; saturates at all-ones.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  8  input frame byte
- s_axis_tvalid  in  1  input byte valid
- s_axis_tlast  in  1  last byte of input frame
- s_axis_tready  out  1  input byte accepted when tvalid&&tready
- m_axis_tdata  out  8  output byte (frame, pad, FCS)
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  asserted on the final FCS byte only
- m_axis_tready  in  1  downstream ready
- busy  out  1  high from first accepted byte until the last FCS byte is transferred

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - state=IDLE; crc state register=32'hFFFFFFFF; byte counter=0.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, busy=0.
  - A mid-frame reset drops the partial frame; no tlast is emitted.
- Output stage: one register. An output slot is free when !m_axis_tvalid || m_axis_tready. All advances (input accept, pad byte, FCS byte, CRC update) happen only on a cycle with a free slot.
- s_axis_tready = slot free && state in {IDLE, DATA}. It is 0 in PAD and FCS.
- CRC sequencing:
  - crc32 instance: i_byte = byte being loaded into the output register; i_crc_state = crc state register; crc_en = that load strobe.
  - crc state register <= o_crc_state on each data or pad load.
  - The register is reloaded to 32'hFFFFFFFF on the IDLE->DATA transition, so it is never stale between frames.
- FCS value: snapshot of crc_out taken on the cycle the last data/pad byte's CRC update completes. Emitted in order fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24].
- State machine:
  - IDLE: on an accepted byte, load it, count=1, go DATA. If tlast is also set, go to PAD or FCS directly (the single-byte frame case).
  - DATA: each accepted byte loads and increments count. On accepted tlast: if padding is enabled and count+1 < MIN_FRAME_LEN, go PAD; else go FCS.
  - PAD: load 8'h00 per free slot and increment count. When count reaches MIN_FRAME_LEN, go FCS.
  - FCS: 2-bit index 0..3. Index 3 loads with m_axis_tlast=1, then go IDLE.
- Latency: first-byte-in to m_axis_tvalid is 1 cycle. Throughput is 1 byte/clk with m_axis_tready held high.
- Back-to-back frames: the next frame's first byte is accepted the cycle after FCS byte 3 is loaded (one idle input cycle).
- Boundaries:
  - A frame of exactly MIN_FRAME_LEN gets no pad.
  - A frame longer than 2^CNT_WIDTH-1 saturates the counter; there is no error.
  - m_axis_tready low holds tdata, tvalid and tlast stable and freezes the CRC.
- busy = (state != IDLE) || m_axis_tvalid.

Optional Feature:
- ETH_FCS_PAD_EN defined: PAD state is present; frames shorter than MIN_FRAME_LEN are zero-padded and the pad bytes are included in the CRC.
- Undefined: PAD state and the MIN_FRAME_LEN comparison are compiled out. DATA goes straight to FCS on tlast; the output is input bytes plus 4 FCS bytes.

Decomposition:
- Shared package eth_mac_pkg:
  - fcs_state_t enum {IDLE, DATA, PAD, FCS}.
  - CRC_INIT = 32'hFFFFFFFF.
  - ETH_MIN_FRAME = 60.
  - FCS_BYTES = 4.
- Sub-module: the existing crc32 (DATA_WIDTH=8), instantiated once. The controller owns the crc state register; crc32 stays purely combinational.

Test Plan:
- Macro off, input ASCII "123456789" (0x31..0x39), tready=1 -> 13 output bytes; bytes 9-12 = 26 39 F4 CB; tlast only on 0xCB; one output byte per cycle after 1-cycle latency.
- Macro on, same 9-byte frame -> 64 output bytes; bytes 9..59 = 0x00; FCS equals the software CRC32 model over the 60 bytes.
- Macro on, 60-byte and 61-byte random frames -> 64 and 65 bytes out, no pad inserted, FCS matches model.
- Random m_axis_tready (50% duty) over 20 frames of 1..1500 bytes -> output byte stream identical to the tready=1 run; tdata stable while tvalid&&!tready.
- Two back-to-back frames with s_axis_tvalid held high -> second frame's FCS is correct, proving the CRC reinitialises to FFFFFFFF.
- reset_n=0 for one cycle mid-payload of a 100-byte frame -> next cycle m_axis_tvalid=0, busy=0, s_axis_tready=0. Following "123456789" frame (macro off) ends 26 39 F4 CB.
